mem_arbiter: RTL and testbench

- Shares one single-port synchronous `memory` instance between two RV32I requesters: instruction fetch (IF, read-only) and data access (D, read/write).
- Issues at most one access per cycle, so `memRead` and `memWrite` are never asserted together.
- Tracks the one-cycle read latency and routes returning read data to the requester that owns it.
- Sits between the core's fetch/LSU stages and the memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/arb_wait_cnt.sv | 24 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for mem_arbiter: the pending-read tag and the wait-counter width.
// Width macros ADDR_WIDTH / WORD_WIDTH fall back to defaults when the build does not set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_arb_pkg;
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_IF   = 2'd1,
    PORT_D    = 2'd2
  } arb_port_e;

  localparam int WAIT_CNT_W   = 4;
  localparam int WAIT_CNT_MAX = (1 << WAIT_CNT_W) - 1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and debug signals around mem_arbiter.
// slave = arbiter view, master = core/memory/bench view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH
) ();
  import mem_arb_pkg::*;

  // Handshake: a requester raises req with its address (and we/wdata for D) and holds
  // them until gnt is seen high in the same cycle; a read grant in cycle N yields
  // rvalid/rdata in cycle N+1; writes commit on the grant cycle with no response.
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [WORD_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WORD_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [WORD_WIDTH-1:0] d_rdata;

  logic                  memRead;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] data_out;

  arb_port_e             dbg_tag;
  logic [WAIT_CNT_W-1:0] dbg_if_wait;
  logic [WAIT_CNT_W-1:0] dbg_d_wait;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, data_out,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output memRead, memWrite, address, data_in,
    output dbg_tag, dbg_if_wait, dbg_d_wait
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, data_out,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  memRead, memWrite, address, data_in,
    input  dbg_tag, dbg_if_wait, dbg_d_wait
  );
endinterface

// File: rtl/arb_wait_cnt.sv
// Per-port starvation counter: counts stalled cycles while req is held, saturating,
// and flags the port once the count reaches MAX_WAIT.
module arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  gnt,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  starved
);
  always_ff @(posedge clk) begin
    if (rst || !req || gnt) begin
      cnt <= '0;
    end else if (cnt != WAIT_CNT_W'(WAIT_CNT_MAX)) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end

  assign starved = (cnt >= WAIT_CNT_W'(MAX_WAIT));
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-IF priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  logic                  if_gnt, d_gnt;
  logic                  if_starved, d_starved;
  logic [WAIT_CNT_W-1:0] if_wait, d_wait;
  logic                  tie_d;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [WORD_WIDTH-1:0] if_rdata_q, d_rdata_q;
  arb_port_e             tag_q, tag_d;

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_if_wait (
    .clk(clk), .rst(rst), .req(bus.if_req), .gnt(if_gnt), .cnt(if_wait), .starved(if_starved)
  );
  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_d_wait (
    .clk(clk), .rst(rst), .req(bus.d_req), .gnt(d_gnt), .cnt(d_wait), .starved(d_starved)
  );

`ifdef MEM_ARB_RR_EN
  logic rr_d_q;  // 1: D wins the next tie

  always_ff @(posedge clk) begin
    if (rst)         rr_d_q <= 1'b0;
    else if (if_gnt) rr_d_q <= 1'b1;
    else if (d_gnt)  rr_d_q <= 1'b0;
  end
  assign tie_d = rr_d_q;
`else
  assign tie_d = 1'b1;
`endif

  // Starvation only matters on a tie; a lone requester is always granted.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.d_req) begin
        if (if_starved)     if_gnt = 1'b1;
        else if (d_starved) d_gnt  = 1'b1;
        else if (tie_d)     d_gnt  = 1'b1;
        else                if_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tag_q <= PORT_NONE;
    else     tag_q <= tag_d;
  end

  always_comb begin
    tag_d = PORT_NONE;
    if (if_gnt)                  tag_d = PORT_IF;
    else if (d_gnt && !bus.d_we) tag_d = PORT_D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (tag_q == PORT_IF) if_rdata_q <= bus.data_out;
      if (tag_q == PORT_D)  d_rdata_q  <= bus.data_out;
    end
  end

  assign addr_sel     = d_gnt ? bus.d_addr : bus.if_addr;
  assign bus.address  = addr_sel;
  assign bus.data_in  = bus.d_wdata;
  assign bus.memRead  = if_gnt | (d_gnt & ~bus.d_we);
  assign bus.memWrite = d_gnt & bus.d_we;
  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;

  // A read in flight when rst rises is dropped, so rvalid is masked during rst too.
  assign bus.if_rvalid = (tag_q == PORT_IF) && !rst;
  assign bus.d_rvalid  = (tag_q == PORT_D) && !rst;
  assign bus.if_rdata  = (tag_q == PORT_IF) ? bus.data_out : if_rdata_q;
  assign bus.d_rdata   = (tag_q == PORT_D) ? bus.data_out : d_rdata_q;

  assign bus.dbg_tag     = tag_q;
  assign bus.dbg_if_wait = if_wait;
  assign bus.dbg_d_wait  = d_wait;

  a_one_strobe: assert property (@(posedge clk) !(bus.memRead && bus.memWrite))
    else $error("memRead and memWrite asserted together");
  a_if_hold: assert property (@(posedge clk) disable iff (rst) (bus.if_req && !if_gnt) |=> bus.if_req)
    else $error("if_req dropped before if_gnt");
  a_d_hold: assert property (@(posedge clk) disable iff (rst) (bus.d_req && !d_gnt) |=> bus.d_req)
    else $error("d_req dropped before d_gnt");
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: synchronous memory model, read-data scoreboard
// and per-scenario tasks. Runs the round-robin scenario when MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW       = `ADDR_WIDTH;
  localparam int WW       = `WORD_WIDTH;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Memory model (environment) and the bench's own reference copy of its contents.
  logic [WW-1:0] mem     [0:(1<<AW)-1];
  logic [WW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.address] <= bus.data_in;
    if (bus.memRead)  bus.data_out     <= mem[bus.address];
  end

  // Scoreboard: expected read data queued at grant, popped when rvalid appears.
  logic [WW-1:0] exp_if_q[$];
  logic [WW-1:0] exp_d_q[$];
  logic          exp_if_v = 1'b0;
  logic          exp_d_v  = 1'b0;
  logic [WW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      n_total++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) $display("FAIL sb_rst_rvalid: got if=%b d=%b want 0", bus.if_rvalid, bus.d_rvalid); else n_pass++;
      exp_if_q.delete(); exp_d_q.delete();
      exp_if_v = 1'b0; exp_d_v = 1'b0;
    end else begin
      n_total++; if (bus.if_rvalid !== exp_if_v) $display("FAIL sb_if_rvalid: got %b want %b", bus.if_rvalid, exp_if_v); else n_pass++;
      if (exp_if_v && bus.if_rvalid === 1'b1) begin
        n_total++;
        if (exp_if_q.size() == 0) $display("FAIL sb_if_empty: got rvalid want no data");
        else begin
          e = exp_if_q.pop_front();
          if (bus.if_rdata !== e) $display("FAIL sb_if_rdata: got %h want %h", bus.if_rdata, e); else n_pass++;
        end
      end
      n_total++; if (bus.d_rvalid !== exp_d_v) $display("FAIL sb_d_rvalid: got %b want %b", bus.d_rvalid, exp_d_v); else n_pass++;
      if (exp_d_v && bus.d_rvalid === 1'b1) begin
        n_total++;
        if (exp_d_q.size() == 0) $display("FAIL sb_d_empty: got rvalid want no data");
        else begin
          e = exp_d_q.pop_front();
          if (bus.d_rdata !== e) $display("FAIL sb_d_rdata: got %h want %h", bus.d_rdata, e); else n_pass++;
        end
      end
      n_total++; if (bus.memRead === 1'b1 && bus.memWrite === 1'b1) $display("FAIL sb_strobes: got rd=1 wr=1 want at most one"); else n_pass++;
      exp_if_v = (bus.if_gnt === 1'b1);
      exp_d_v  = (bus.d_gnt === 1'b1) && (bus.d_we === 1'b0);
      if (exp_if_v) exp_if_q.push_back(ref_mem[bus.if_addr]);
      if (exp_d_v)  exp_d_q.push_back(ref_mem[bus.d_addr]);
      if (bus.d_gnt === 1'b1 && bus.d_we === 1'b1) ref_mem[bus.d_addr] = bus.d_wdata;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_if(input logic req, input logic [AW-1:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [AW-1:0] addr, input logic [WW-1:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_if(1'b1, AW'('h3));
    drive_d(1'b1, 1'b0, AW'('h5), '0);
    tick(); tick();
    @(negedge clk);
    n_total++; if (bus.if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b want 0", bus.if_gnt); else n_pass++;
    n_total++; if (bus.d_gnt !== 1'b0) $display("FAIL rst_d_gnt: got %b want 0", bus.d_gnt); else n_pass++;
    n_total++; if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) $display("FAIL rst_strobes: got rd=%b wr=%b want 0", bus.memRead, bus.memWrite); else n_pass++;
    tick();
    drive_if(1'b0, '0);
    drive_d(1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.dbg_tag !== PORT_NONE) $display("FAIL rst_tag: got %0d want NONE", bus.dbg_tag); else n_pass++;
    n_total++; if (bus.dbg_if_wait !== '0 || bus.dbg_d_wait !== '0) $display("FAIL rst_wait: got if=%0d d=%0d want 0", bus.dbg_if_wait, bus.dbg_d_wait); else n_pass++;
    n_total++; if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) $display("FAIL idle_gnt: got if=%b d=%b want 0", bus.if_gnt, bus.d_gnt); else n_pass++;
    tick();
  endtask

  task automatic test_if_read();
    drive_if(1'b1, AW'('h10));
    @(negedge clk);
    n_total++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) $display("FAIL ifrd_gnt: got if=%b d=%b want 1/0", bus.if_gnt, bus.d_gnt); else n_pass++;
    n_total++; if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0) $display("FAIL ifrd_strobes: got rd=%b wr=%b want 1/0", bus.memRead, bus.memWrite); else n_pass++;
    n_total++; if (bus.address !== AW'('h10)) $display("FAIL ifrd_addr: got %h want 10", bus.address); else n_pass++;
    tick();
    drive_if(1'b0, '0);
    @(negedge clk);
    n_total++; if (bus.if_rvalid !== 1'b1) $display("FAIL ifrd_rvalid: got %b want 1", bus.if_rvalid); else n_pass++;
    n_total++; if (bus.if_rdata !== 32'hDEADBEEF) $display("FAIL ifrd_rdata: got %h want deadbeef", bus.if_rdata); else n_pass++;
    n_total++; if (bus.d_rvalid !== 1'b0) $display("FAIL ifrd_d_rvalid: got %b want 0", bus.d_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    drive_if(1'b1, AW'('h11));
    drive_d(1'b1, 1'b0, AW'('h12), '0);
    @(negedge clk);
    n_total++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) $display("FAIL prio_tie: got if=%b d=%b want 0/1", bus.if_gnt, bus.d_gnt); else n_pass++;
    n_total++; if (bus.address !== AW'('h12)) $display("FAIL prio_addr: got %h want 12", bus.address); else n_pass++;
    tick();
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++; if (bus.if_gnt !== 1'b1) $display("FAIL prio_if_next: got %b want 1", bus.if_gnt); else n_pass++;
    n_total++; if (bus.d_rdata !== 32'hC0DE0012) $display("FAIL prio_d_rdata: got %h want c0de0012", bus.d_rdata); else n_pass++;
    tick();
    drive_if(1'b0, '0);
    @(negedge clk);
    n_total++; if (bus.if_rdata !== 32'hC0DE0011) $display("FAIL prio_if_rdata: got %h want c0de0011", bus.if_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    drive_if(1'b1, AW'('h4));
    drive_d(1'b1, 1'b1, AW'('h8), 32'h1234);
    for (int c = 0; c <= MAX_WAIT; c++) begin
      @(negedge clk);
      n_total++; if (bus.if_gnt !== (c == MAX_WAIT) || bus.d_gnt !== (c != MAX_WAIT)) $display("FAIL starve_gnt_c%0d: got if=%b d=%b want %b/%b", c, bus.if_gnt, bus.d_gnt, c == MAX_WAIT, c != MAX_WAIT); else n_pass++;
      n_total++; if (bus.dbg_if_wait !== WAIT_CNT_W'(c)) $display("FAIL starve_wait_c%0d: got %0d want %0d", c, bus.dbg_if_wait, c); else n_pass++;
      tick();
      if (c == MAX_WAIT) drive_if(1'b0, '0);
    end
    @(negedge clk);
    n_total++; if (bus.d_gnt !== 1'b1) $display("FAIL starve_d_back: got %b want 1", bus.d_gnt); else n_pass++;
    n_total++; if (bus.dbg_d_wait !== WAIT_CNT_W'(1) || bus.dbg_if_wait !== '0) $display("FAIL starve_cnts: got d=%0d if=%0d want 1/0", bus.dbg_d_wait, bus.dbg_if_wait); else n_pass++;
    n_total++; if (bus.if_rdata !== 32'hC0DE0004) $display("FAIL starve_if_rdata: got %h want c0de0004", bus.if_rdata); else n_pass++;
    tick();
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++; if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) $display("FAIL starve_idle: got rd=%b wr=%b want 0", bus.memRead, bus.memWrite); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive_d(1'b1, 1'b0, AW'(k + 1), '0);
      else       drive_d(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (k < 3) begin
        n_total++; if (bus.d_gnt !== 1'b1) $display("FAIL b2b_gnt_%0d: got %b want 1", k, bus.d_gnt); else n_pass++;
      end
      if (k > 0) begin
        n_total++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== (32'hC0DE0000 | k)) $display("FAIL b2b_data_%0d: got v=%b %h want 1 %h", k, bus.d_rvalid, bus.d_rdata, 32'hC0DE0000 | k); else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_total++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'hC0DE0003) $display("FAIL b2b_hold: got v=%b %h want 0 c0de0003", bus.d_rvalid, bus.d_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    drive_d(1'b1, 1'b1, AW'('h20), 32'hA5A5A5A5);
    @(negedge clk);
    n_total++; if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 || bus.data_in !== 32'hA5A5A5A5) $display("FAIL wr_drive: got wr=%b rd=%b %h want 1/0 a5a5a5a5", bus.memWrite, bus.memRead, bus.data_in); else n_pass++;
    tick();
    drive_d(1'b1, 1'b0, AW'('h20), '0);
    @(negedge clk);
    n_total++; if (bus.memRead !== 1'b1 || bus.d_rvalid !== 1'b0) $display("FAIL wr_then_rd: got rd=%b v=%b want 1/0", bus.memRead, bus.d_rvalid); else n_pass++;
    tick();
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA5A5A5A5) $display("FAIL raw_data: got v=%b %h want 1 a5a5a5a5", bus.d_rvalid, bus.d_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive_if(1'b1, AW'('h30));
    @(negedge clk);
    n_total++; if (bus.if_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b want 1", bus.if_gnt); else n_pass++;
    tick();
    drive_if(1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.if_rvalid !== 1'b0) $display("FAIL midrst_rvalid: got %b want 0", bus.if_rvalid); else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.if_rvalid !== 1'b0 || bus.dbg_tag !== PORT_NONE) $display("FAIL midrst_after: got v=%b tag=%0d want 0 NONE", bus.if_rvalid, bus.dbg_tag); else n_pass++;
    n_total++; if (bus.dbg_if_wait !== '0 || bus.dbg_d_wait !== '0) $display("FAIL midrst_wait: got if=%0d d=%0d want 0", bus.dbg_if_wait, bus.dbg_d_wait); else n_pass++;
    tick();
  endtask

  task automatic test_rr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_if(1'b1, AW'('h40));
    drive_d(1'b1, 1'b0, AW'('h41), '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++; if (bus.if_gnt !== (k % 2 == 0) || bus.d_gnt !== (k % 2 == 1)) $display("FAIL rr_gnt_%0d: got if=%b d=%b want %b/%b", k, bus.if_gnt, bus.d_gnt, k % 2 == 0, k % 2 == 1); else n_pass++;
      tick();
    end
    drive_if(1'b0, '0);
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = WW'(32'hC0DE0000 | i);
      ref_mem[i] = WW'(32'hC0DE0000 | i);
    end
    mem[16]     = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    drive_if(1'b0, '0);
    drive_d(1'b0, 1'b0, '0, '0);

    test_reset();
    test_if_read();
`ifndef MEM_ARB_RR_EN
    test_priority();
    test_starvation();
`endif
    test_back_to_back();
    test_write_read();
    test_reset_mid_read();
`ifdef MEM_ARB_RR_EN
    test_rr();
`endif
    @(negedge clk);
    n_total++; if (exp_if_q.size() != 0 || exp_d_q.size() != 0) $display("FAIL sb_drain: got if=%0d d=%0d left want 0", exp_if_q.size(), exp_d_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
